// File: rtl/rx_stream_scheduler_pkg.sv
// Shared types and helpers for the Rx stream scheduler and its serializer interface.
package rx_sched_pkg;

    localparam int IQ_W   = 24;
    localparam int MAX_NR = 8;
    localparam int BUS_W  = MAX_NR * IQ_W;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SELECT   = 3'd1,
        ISSUE    = 3'd2,
        WAIT_ACK = 3'd3,
        RELEASE  = 3'd4
    } sched_state_e;

    // Receiver idx occupies bits [IQ_W*idx +: IQ_W] of a packed sample bus.
    function automatic logic signed [IQ_W-1:0] iq_slice(input logic [BUS_W-1:0] bus,
                                                         input int idx);
        return IQ_W'(bus >> (idx * IQ_W));
    endfunction

endpackage

// File: rtl/rx_stream_scheduler_if.sv
// Frame handshake between the Rx scheduler (master) and the Rx serializer (slave).
interface rx_stream_scheduler_if #(
    parameter int NR  = 8,
    parameter int RXW = $clog2(NR)
);
    import rx_sched_pkg::*;

    logic                   ser_req;
    logic                   ser_ack;
    logic [RXW-1:0]         ser_rx_number;
    logic signed [IQ_W-1:0] ser_I;
    logic signed [IQ_W-1:0] ser_Q;
    logic                   ser_sync;
    logic signed [IQ_W-1:0] ser_sync_I;
    logic signed [IQ_W-1:0] ser_sync_Q;

    modport master (
        output ser_req, ser_rx_number, ser_I, ser_Q, ser_sync, ser_sync_I, ser_sync_Q,
        input  ser_ack
    );

    modport slave (
        input  ser_req, ser_rx_number, ser_I, ser_Q, ser_sync, ser_sync_I, ser_sync_Q,
        output ser_ack
    );

endinterface

// File: rtl/rx_stream_scheduler_rr_pick.sv
// Combinational round-robin finder: first set bit of elig strictly after ptr, wrapping modulo NR.
module rr_pick #(
    parameter int NR  = 8,
    parameter int RXW = $clog2(NR)
) (
    input  logic [NR-1:0]  elig,
    input  logic [RXW-1:0] ptr,
    output logic           valid,
    output logic [RXW-1:0] idx
);

    logic [RXW-1:0] cand;

    // Scan farthest-first so the nearest eligible index after ptr is the last one written.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = NR; k >= 1; k--) begin
            cand = RXW'((int'(ptr) + k) % NR);
            if (elig[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rx_stream_scheduler.sv
// Round-robin scheduler sharing the Rx serializer between NR DDC receivers, with
// optional pairing of a sync/PureSignal slave sample onto its base receiver's frame.
module rx_stream_scheduler
    import rx_sched_pkg::*;
#(
    parameter int NR  = 8,
    parameter int RXW = $clog2(NR)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NR-1:0]        rx_enable,
    input  logic [NR-1:0]        sync_mask,
    input  logic [NR-1:0]        rx_strobe,
    input  logic [NR*IQ_W-1:0]   rx_I,
    input  logic [NR*IQ_W-1:0]   rx_Q,
    input  logic                 flush,
    input  logic                 overrun_clr,
    rx_stream_scheduler_if.master ser,
    output logic [NR-1:0]        overrun,
    output logic                 busy
);

    sched_state_e           state;
    logic [NR-1:0]          pending;
    logic [NR-1:0]          cap;
    logic [NR-1:0]          is_slave;
    logic [NR-1:0]          pair_req;
    logic [NR-1:0]          partner_ok;
    logic [NR-1:0]          elig;
    logic [NR-1:0]          issue_clr;
    logic [NR-1:0]          ovr_set;
    logic [NR-1:0]          pend_next;
    logic [RXW-1:0]         rr_ptr;
    logic [RXW-1:0]         grant;
    logic [RXW-1:0]         grant_p1;
    logic [RXW-1:0]         pick_idx;
    logic                   pick_valid;
    logic                   grant_sync;
    logic [BUS_W-1:0]       bus_i;
    logic [BUS_W-1:0]       bus_q;
    logic signed [IQ_W-1:0] hold_i [NR];
    logic signed [IQ_W-1:0] hold_q [NR];

    assign bus_i = BUS_W'(rx_I);
    assign bus_q = BUS_W'(rx_Q);

    assign cap        = rx_strobe & rx_enable;
    assign is_slave   = sync_mask & {{(NR-1){1'b1}}, 1'b0};
    assign pair_req   = sync_mask >> 1;
    assign partner_ok = (rx_enable & pending) >> 1;
    // A base receiver that owns a slave waits until the slave sample is also present.
    assign elig       = rx_enable & pending & ~is_slave & (~pair_req | partner_ok)
                      & ~{NR{flush}};
    assign grant_p1   = grant + 1'b1;
    assign busy       = (state != IDLE);

    always_comb begin
        issue_clr = '0;
        if (state == ISSUE) begin
            issue_clr[grant] = 1'b1;
            if (grant_sync) issue_clr[grant_p1] = 1'b1;
        end
    end

    // A strobe landing on the ISSUE clear refills pending without counting as an overrun.
    assign ovr_set   = cap & pending & ~issue_clr & ~{NR{flush}};
    assign pend_next = flush ? '0 : (((pending & ~issue_clr) | cap) & rx_enable);

    rr_pick #(.NR(NR), .RXW(RXW)) u_rr_pick (
        .elig  (elig),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NR; i++) begin
                hold_i[i] <= '0;
                hold_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (cap[i]) begin
                    hold_i[i] <= iq_slice(bus_i, i);
                    hold_q[i] <= iq_slice(bus_q, i);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            pending           <= '0;
            overrun           <= '0;
            rr_ptr            <= RXW'(NR - 1);
            grant             <= '0;
            grant_sync        <= 1'b0;
            ser.ser_req       <= 1'b0;
            ser.ser_rx_number <= '0;
            ser.ser_I         <= '0;
            ser.ser_Q         <= '0;
            ser.ser_sync      <= 1'b0;
            ser.ser_sync_I    <= '0;
            ser.ser_sync_Q    <= '0;
        end else begin
            pending <= pend_next;
            overrun <= (overrun & ~{NR{overrun_clr}}) | ovr_set;
            case (state)
                IDLE: begin
                    if (|elig) state <= SELECT;
                end
                SELECT: begin
                    // Pairing is frozen here so later sync_mask edits wait for the next grant.
                    if (pick_valid) begin
                        grant      <= pick_idx;
                        grant_sync <= pair_req[pick_idx];
                        state      <= ISSUE;
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    ser.ser_rx_number <= grant;
                    ser.ser_I         <= hold_i[grant];
                    ser.ser_Q         <= hold_q[grant];
                    ser.ser_sync      <= grant_sync;
                    ser.ser_sync_I    <= grant_sync ? hold_i[grant_p1] : '0;
                    ser.ser_sync_Q    <= grant_sync ? hold_q[grant_p1] : '0;
                    ser.ser_req       <= 1'b1;
                    rr_ptr            <= grant;
                    state             <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (ser.ser_ack) begin
                        ser.ser_req    <= 1'b0;
                        ser.ser_sync   <= 1'b0;
                        ser.ser_sync_I <= '0;
                        ser.ser_sync_Q <= '0;
                        state          <= RELEASE;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
